// File: rtl/top_key_pkg.sv
// Shared types for the raw-key front end: the 9-bit key code carried on the key stream.
package top_key_pkg;

    localparam int key_code_width_c = 9;

    typedef struct packed {
        logic       press;
        logic [7:0] idx;
    } key_code_t;

endpackage

// File: rtl/top_key_fifo.sv
// Synchronous FIFO with full/empty flags; head entry reads as zero while empty.
module top_key_fifo #(
    parameter int width_p = 9,
    parameter int depth_p = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [width_p-1:0] din,
    input  logic               pop,
    output logic [width_p-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int addr_w_c = $clog2(depth_p);
    localparam int one_i    = 1;

    localparam logic [addr_w_c-1:0] ptr_one_c = one_i[addr_w_c-1:0];
    localparam logic [addr_w_c:0]   cnt_one_c = one_i[addr_w_c:0];
    localparam logic [addr_w_c:0]   depth_c   = depth_p[addr_w_c:0];

    logic [width_p-1:0]  mem [depth_p];
    logic [addr_w_c-1:0] wr_ptr, rd_ptr;
    logic [addr_w_c:0]   count;
    logic                do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == depth_c);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_one_c;
            if (do_pop)  rd_ptr <= rd_ptr + ptr_one_c;
            case ({do_push, do_pop})
                2'b10:   count <= count + cnt_one_c;
                2'b01:   count <= count - cnt_one_c;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until a push has filled it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/top_key_scan.sv
// Key scanner: synchronise and debounce each key line, encode stable flips as press/release
// codes in ascending index order, and buffer them onto the valid/accept key stream.
module top_key_scan
    import top_key_pkg::*;
#(
    parameter int keys_p     = 16,
    parameter int tick_div_p = 1000,
    parameter int debounce_p = 4,
    parameter int depth_p    = 4
) (
    input  logic              main_clk_i,
    input  logic              main_rst_i,
    input  logic [keys_p-1:0] keys_i,
    output logic              key_valid_o,
    input  logic              key_accept_i,
    output logic [8:0]        key_data_o,
    output logic              busy_o
);

    localparam int presc_w_c  = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
    localparam int presc_last = tick_div_p - 1;
    localparam int one_i      = 1;
    localparam int deb_sat    = debounce_p - 1;

    localparam logic [presc_w_c-1:0] presc_last_c = presc_last[presc_w_c-1:0];
    localparam logic [presc_w_c-1:0] presc_one_c  = one_i[presc_w_c-1:0];
    localparam logic [3:0]           deb_c        = debounce_p[3:0];
    localparam logic [3:0]           sat_c        = deb_sat[3:0];

    logic [keys_p-1:0]    sync_a, sync_b;
    logic [presc_w_c-1:0] presc;
    logic                 tick;
    logic [keys_p-1:0]    stable_vec, pend_vec, sel_onehot, clr_vec;
    logic                 sel_valid, push, fifo_full, fifo_empty;
    key_code_t            sel_code;

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= keys_i;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i)  presc <= '0;
        else if (tick)   presc <= '0;
        else             presc <= presc + presc_one_c;
    end

    assign tick = (presc == presc_last_c);

    for (genvar g = 0; g < keys_p; g++) begin : g_key
        logic       stable_q;
        logic       pend_q;
        logic [3:0] cnt_q;

        always_ff @(posedge main_clk_i) begin
            if (main_rst_i) begin
                stable_q <= 1'b0;
                pend_q   <= 1'b0;
                cnt_q    <= '0;
            end else begin
                if (clr_vec[g]) pend_q <= 1'b0;
                if (tick) begin
                    if (sync_b[g] == stable_q) begin
                        cnt_q <= '0;
                    end else if (pend_q) begin
                        // Unreported flip still queued: hold just below threshold so it fires once freed.
                        cnt_q <= (cnt_q == sat_c) ? sat_c : cnt_q + 4'd1;
                    end else if (cnt_q + 4'd1 == deb_c) begin
                        stable_q <= ~stable_q;
                        cnt_q    <= '0;
                        pend_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
            end
        end

        assign stable_vec[g] = stable_q;
        assign pend_vec[g]   = pend_q;
    end

    // Scan from the top so the lowest pending index wins.
    always_comb begin
        sel_valid  = 1'b0;
        sel_onehot = '0;
        sel_code   = '0;
        for (int i = keys_p - 1; i >= 0; i--) begin
            if (pend_vec[i]) begin
                sel_valid      = 1'b1;
                sel_onehot     = '0;
                sel_onehot[i]  = 1'b1;
                sel_code.press = stable_vec[i];
                sel_code.idx   = 8'(i);
            end
        end
    end

    assign push    = sel_valid && !fifo_full;
    assign clr_vec = push ? sel_onehot : '0;

    top_key_fifo #(
        .width_p (key_code_width_c),
        .depth_p (depth_p)
    ) u_fifo (
        .clk   (main_clk_i),
        .rst   (main_rst_i),
        .push  (push),
        .din   (sel_code),
        .pop   (key_accept_i),
        .dout  (key_data_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign key_valid_o = !fifo_empty;
    assign busy_o      = (|pend_vec) || !fifo_empty;

endmodule

// File: doc/top_key_scan.md
# top_key_scan

Raw-key front end for the `top` library. It takes asynchronous push-button lines, synchronises and debounces each one, and turns every stable press or release into a 9-bit key code. Codes are buffered in a small FIFO and delivered over the valid/accept `key` stream that `top_core` consumes on `key_valid_i`/`key_accept_o`/`key_data_i`.

## Interface
- `keys_p`, default 16: number of key lines, 1..256.
- `tick_div_p`, default 1000: clock cycles per debounce sample, ≥1.
- `debounce_p`, default 4: consecutive differing samples required to flip a key's stable state, 1..15.
- `depth_p`, default 4: output FIFO depth, power of two, ≥2.
- Clocking is decided: one clock; reset is synchronous and active-high.
- `main_clk_i`  in  1: clock.
- `main_rst_i`  in  1: synchronous reset, active-high.
- `keys_i`  in  `keys_p`: raw key lines, asynchronous, 1 = pressed.
- `key_valid_o`  out  1: a code is available.
- `key_accept_i`  in  1: the consumer takes the code.
- `key_data_o`  out  9: bit [8] = 1 for press, 0 for release; bits [7:0] = key index.
- `busy_o`  out  1: at least one pending bit is set or the FIFO is not empty.

## Operation
- Synchroniser: a 2-flop chain on every line. It runs every cycle.
- Prescaler: counts 0..`tick_div_p`-1 and wraps. `tick` is asserted in the cycle the count equals `tick_div_p`-1.
- Debounce, per key, on each tick:
  - If the synchronised sample equals the stable state, the counter clears to 0.
  - If the sample differs, the counter increments.
  - When the counter would reach `debounce_p`, the stable state toggles, the counter clears, and the key's pending bit is set.
  - While the key's pending bit is set, its counter saturates at `debounce_p`-1 and no flip occurs. No event is ever lost.
- Encoder:
  - Each cycle the FIFO is not full, the lowest-index pending bit is selected.
  - It writes the code {stable[i], i} to the FIFO and clears that pending bit.
  - At most one write per cycle.
- FIFO:
  - `key_valid_o` = not empty. `key_data_o` = head entry.
  - A pop occurs on `key_valid_o && key_accept_i`.
  - Push and pop in the same cycle keep the count unchanged.
  - Push while full is impossible: the encoder stalls.
- Stream rules:
  - Once asserted, `key_valid_o` stays high and `key_data_o` stays stable until accepted.
  - `key_accept_i` is ignored while `key_valid_o` is low.
- Reset (synchronous):
  - Synchroniser flops, stable states, counters, pending bits and prescaler are cleared to 0. The FIFO is emptied.
  - `key_valid_o`, `key_data_o` and `busy_o` go to 0 in the cycle after reset is sampled.
  - Reset mid-operation discards every pending and buffered event.
  - A key held through reset produces a press event once debounced after reset.

## Timing
- Input change to synchronised sample: 2 cycles.
- Stable flip: registered at the tick edge. Pending bit set on the same edge.
- Pending bit to FIFO write: 1 cycle. FIFO write to `key_valid_o`: 1 cycle.
- Uncongested, the first code is visible 2 cycles after the flipping tick.
- Simultaneous flips on one tick: codes appear in ascending index order, one per cycle while the FIFO has space.
- Throughput: one code per cycle in, one per cycle out.

## Structure
- Package `top_key_pkg` holds:
  - `key_code_t`: packed struct {`press`, `idx[7:0]`}.
  - Constant `key_code_width_c` = 9.
- Sub-module `top_key_fifo`: synchronous FIFO parameterised by width and depth, with full/empty flags and synchronous active-high reset.
- Debounce is a generate loop over `keys_p`. Priority select is a combinational loop.

## Test plan
Unless stated otherwise, `tick_div_p`=4 and `debounce_p`=3.
- Single press and release:
  - Drive `keys_i`[3] 0→1 and hold → exactly one code 9'h103 within 20 cycles, `key_accept_i` held 1.
  - Release → exactly one code 9'h003.
- Bounce:
  - Toggle `keys_i`[0] every 5 cycles for 40 cycles, then hold at 1 → one 9'h100 only, no intermediate codes.
- Simultaneous flips:
  - Raise `keys_i`[5] and `keys_i`[2] in the same cycle → 9'h102 then 9'h105 on consecutive cycles.
- Backpressure, `depth_p`=4:
  - Hold `key_accept_i`=0 and generate 6 presses → FIFO holds 4, `busy_o`=1, `key_data_o` stable.
  - Release accept → all 6 codes delivered in index order, none lost.
  - Pending keys do not re-flip while blocked.
- Reset mid-operation:
  - Assert `main_rst_i` with 3 codes buffered → next cycle `key_valid_o`=0, `busy_o`=0.
  - A key still held afterwards yields a single fresh press code.
- Tick boundary, `tick_div_p`=1:
  - Sampling every cycle → press is debounced in `debounce_p` cycles after synchronisation. Code appears 2 cycles after the flip.
